// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states, divide length.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the MDU; flush exists only with MDU_FLUSH_EN.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  op_e         op;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MDU_FLUSH_EN
  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
`else
  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/div_iter.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_iter (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_nx,
  output logic [31:0] quo_nx
);
  logic [32:0] sh;
  logic [32:0] diff;

  always_comb begin
    sh     = {rem, quo[31]};
    diff   = sh - {1'b0, dvs};
    // borrow out means the trial went negative: restore
    rem_nx = diff[32] ? sh[31:0] : diff[31:0];
    quo_nx = {quo[30:0], ~diff[32]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MDU: single-cycle 32x32 multiply, 32-cycle restoring divide.
// Optional MDU_FLUSH_EN adds a flush input that cancels any operation.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mdu_if.slave m
);
  state_e      state_q, state_d;
  cnt_t        cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rem_q, quo_q, dvs_q, araw_q;
  logic        qneg_q, rneg_q, dz_q;

  logic        kill, accept, is_div, is_sgn, last;
  logic [63:0] ma, mb, prod;
  logic [31:0] rem_nx, quo_nx, q_fix, r_fix;

`ifdef MDU_FLUSH_EN
  assign kill = m.flush;
`else
  assign kill = 1'b0;
`endif

  assign is_div = (m.op == OP_DIV) || (m.op == OP_DIVU);
  assign is_sgn = (m.op == OP_MULT) || (m.op == OP_DIV);
  assign accept = m.start && !kill && (state_q == S_IDLE || state_q == S_DONE);
  assign last   = (cnt_q == cnt_t'(DIV_CYCLES - 1));

  // operands widened to 64 bits so one multiplier covers both signednesses
  always_comb begin
    ma   = is_sgn ? 64'($signed(m.a)) : {32'd0, m.a};
    mb   = is_sgn ? 64'($signed(m.b)) : {32'd0, m.b};
    prod = ma * mb;
  end

  div_iter u_iter (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  assign q_fix = qneg_q ? (32'd0 - quo_nx) : quo_nx;
  assign r_fix = rneg_q ? (32'd0 - rem_nx) : rem_nx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = is_div ? S_DIV : S_DONE;
        else        state_d = S_IDLE;
      end
      S_DIV:   if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      araw_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (!kill) begin
      if (accept) begin
        if (!is_div) begin
          {hi_q, lo_q} <= prod;
        end else begin
          cnt_q  <= '0;
          rem_q  <= '0;
          quo_q  <= is_sgn ? abs32(m.a) : m.a;
          dvs_q  <= is_sgn ? abs32(m.b) : m.b;
          araw_q <= m.a;
          qneg_q <= is_sgn && (m.a[31] ^ m.b[31]);
          rneg_q <= is_sgn && m.a[31];
          dz_q   <= (m.b == 32'd0);
        end
      end else if (state_q == S_DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 1'b1;
        // hi/lo only change here, so partial divide state never leaks out
        if (last) begin
          hi_q <= dz_q ? araw_q : r_fix;
          lo_q <= dz_q ? 32'hFFFF_FFFF : q_fix;
        end
      end
    end
  end

  assign m.busy = (state_q == S_DIV);
  assign m.done = (state_q == S_DONE);
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences, random ops vs model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mdu_if bus();
  mul_div_unit dut (.clk(clk), .rst(rst), .m(bus));

  always #5 clk = ~clk;

  typedef struct {
    op_e         op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference: plain arithmetic on 64-bit integers
  function automatic logic [63:0] model(input op_e o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin q = sa * sb; p = q; end
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // call at a negedge; returns at the negedge of the cycle after acceptance
  task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = o; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // counts cycles after acceptance until done; optionally pulses a stray start at cycle inj
  task automatic wait_done(input int inj, output int lat, output int bc);
    lat = 1; bc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bc++;
      if (lat == inj) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'h1234; bus.b = 32'h10;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int inj);
    int lat, bc;
    logic isdiv;
    isdiv = (o == OP_DIV) || (o == OP_DIVU);
    issue(o, a, b);
    wait_done(inj, lat, bc);
    chk({nm, " latency"}, 64'(lat), isdiv ? 64'd33 : 64'd1);
    chk({nm, " busy cycles"}, 64'(bc), isdiv ? 64'd32 : 64'd0);
    chk({nm, " hi/lo"}, {bus.hi, bus.lo}, exp);
    @(negedge clk);
    chk({nm, " done pulse width"}, {62'd0, bus.done, bus.busy}, 64'd0);
    chk({nm, " hi/lo hold"}, {bus.hi, bus.lo}, exp);
  endtask

  task automatic watch_no_done(input string nm, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.done) cnt++;
      @(negedge clk);
    end
    chk(nm, 64'(cnt), 64'd0);
  endtask

  vec_t vt[$];

  initial begin
    logic [63:0] prev;
    op_e         ro;
    logic [31:0] ra, rb;
    int          lat, bc;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
`ifdef MDU_FLUSH_EN
    bus.flush = 1'b0;
`endif
    @(negedge clk);
    // reset must win over a concurrent start
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd7; bus.b = 32'd9;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    chk("reset state", {bus.hi, bus.lo}, 64'd0);
    chk("reset flags", {62'd0, bus.busy, bus.done}, 64'd0);

    vt.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vt.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vt.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vt.push_back('{OP_MULTU, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000});
    vt.push_back('{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vt.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vt.push_back('{OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vt.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003});
    vt.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vt.push_back('{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vt.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 32'hFFFF_FFFF});
    vt.push_back('{OP_DIVU,  32'd9,        32'd4,        32'h0000_0001, 32'h0000_0002});

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, 0);

    // divide by zero with a stray start at cycle 10 that must be dropped
    run_op("divu by zero + stray start", OP_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 10);

    // reset at cycle 15 of a divide
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid-div flags", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("rst mid-div hi/lo", {bus.hi, bus.lo}, 64'd0);
    watch_no_done("rst mid-div no done", 40);
    run_op("mult after rst", OP_MULT, 32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 0);

`ifdef MDU_FLUSH_EN
    prev = {bus.hi, bus.lo};
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush mid-div flags", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("flush mid-div hi/lo", {bus.hi, bus.lo}, prev);
    watch_no_done("flush mid-div no done", 40);
    bus.flush = 1'b1;
    issue(OP_MULTU, 32'd3, 32'd3);
    bus.flush = 1'b0;
    chk("flush beats start", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("flush beats start hi/lo", {bus.hi, bus.lo}, prev);
    run_op("mult after flush", OP_MULTU, 32'd11, 32'd13, 64'd143, 0);
`endif

    // back-to-back: divide issued during the multiply's done cycle
    issue(OP_MULTU, 32'd3, 32'd5);
    chk("b2b mult done", {63'd0, bus.done}, 64'd1);
    chk("b2b mult hi/lo", {bus.hi, bus.lo}, 64'd15);
    issue(OP_DIVU, 32'd9, 32'd4);
    wait_done(0, lat, bc);
    chk("b2b div latency", 64'(lat), 64'd33);
    chk("b2b div hi/lo", {bus.hi, bus.lo}, {32'd1, 32'd2});
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ro = op_e'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'd0 - $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-004 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have port a, input, 32 bits: multiplicand or dividend.
REQ-006 The block SHALL have port b, input, 32 bits: multiplier or divisor.
REQ-007 The block SHALL have port flush, input, 1 bit: cancel the in-flight operation (present only with MDU_FLUSH_EN).
REQ-008 The block SHALL have port busy, output, 1 bit: divide in progress, pipeline must stall.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse meaning hi/lo are valid; drives the HI/LO write enable downstream.
REQ-010 The block SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-011 The block SHALL have port lo, output, 32 bits: product[31:0] or quotient.

Function
REQ-012 The FSM SHALL have states IDLE, DIV and DONE; all state and output updates SHALL occur on the rising clock edge.
REQ-013 start SHALL be accepted only in IDLE or DONE; in DIV it SHALL be ignored with no queuing.
REQ-014 MULT/MULTU acceptance SHALL register the full 64-bit product (signed or unsigned, per op) into {hi,lo} and go to DONE; done SHALL be high the next cycle (latency 1).
REQ-015 DIV/DIVU acceptance SHALL latch |a|, |b| (signed ops) or a, b (unsigned ops), clear the iteration counter and go to DIV.
REQ-016 DIV SHALL perform one restoring iteration per cycle for exactly 32 cycles; on the 32nd edge the sign-corrected results SHALL be written to hi/lo and the FSM SHALL enter DONE (start-to-done latency 33 cycles).
REQ-017 Signed division SHALL give quotient sign = a[31]^b[31] and remainder sign = a[31]; magnitude SHALL follow truncation toward zero.
REQ-018 Divide by zero SHALL still take 33 cycles and yield lo=32'hFFFFFFFF, hi=a, for both DIV and DIVU.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap, no trap).
REQ-020 busy SHALL be high exactly while state==DIV, and SHALL NOT be asserted for multiply.
REQ-021 done SHALL be high exactly while state==DONE; DONE SHALL return to IDLE next cycle unless a new start is accepted.
REQ-022 hi/lo SHALL hold their last value except at result write; intermediate divide state SHALL NOT be visible on hi/lo.

Reset
REQ-023 rst SHALL force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0; it SHALL take priority over start and flush.
REQ-024 rst asserted mid-divide SHALL abort the operation with no done pulse.

Configuration
REQ-025 With MDU_FLUSH_EN defined, flush=1 SHALL force IDLE on the next edge from any state, with no done and hi/lo unchanged; flush SHALL take priority over a same-cycle start.
REQ-026 Without MDU_FLUSH_EN defined, the flush port and its logic SHALL be absent, and a divide SHALL always run to completion.

Structure
REQ-027 Package mdu_pkg SHALL hold the op encodings, the FSM state enum and DIV_CYCLES=32.
REQ-028 Sub-module div_iter SHALL be a combinational single restoring step: {rem,quo} in, trial subtract, {rem,quo} out.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> done next cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy never high.
REQ-030 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 DIV a=-7, b=2 -> busy for 32 cycles, done in cycle 33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-032 DIVU a=100, b=0 -> done at 33, lo=0xFFFFFFFF, hi=100; a start pulse at cycle 10 is ignored.
REQ-033 DIV in flight, rst (or flush with MDU_FLUSH_EN) at cycle 15 -> no done, hi/lo unchanged, IDLE next cycle; a new MULT is then accepted normally.
REQ-034 Back-to-back: start DIVU 9/4 issued in the DONE cycle of a prior MULT -> that MULT's done is seen, then done at 33 with lo=2, hi=1.
